// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit per clock.
// Single full-subtractor cell, registered borrow, start/busy/done handshake with held results.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the first WIDTH-1 result bits; the final bit joins on the publishing edge.
    logic [WIDTH-2:0] res_q, res_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic             d_bit;
    logic             bor_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
        bor_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bor_q);
        res_next = {d_bit, res_q};

        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_d      = res_q;
        bor_d      = bor_q;
        cnt_d      = cnt_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_next[WIDTH-1:1];
                bor_d  = bor_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    state_d    = StDone;
                    diff_d     = res_next;
                    borrow_d   = bor_next;
                    overflow_d = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
                    zero_d     = (res_next == '0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_q      <= '0;
            bor_q      <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_q      <= res_d;
            bor_q      <= bor_d;
            cnt_q      <= cnt_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at issue time and
// compared by an independent monitor whenever done pulses.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         zero;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         overflow;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    exp_t pub;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sx, sy, sd;
        e.diff     = x - y;
        e.borrow   = (x < y);
        sx         = $signed(x);
        sy         = $signed(y);
        sd         = sx - sy;
        e.overflow = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        e.zero     = (e.diff == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".diff"}, 32'(diff), 32'(e.diff));
        chk({tag, ".borrow"}, 32'(borrow), 32'(e.borrow));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e.overflow));
        chk({tag, ".zero"}, 32'(zero), 32'(e.zero));
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                chk_outputs("result", sb.pop_front());
            end
        end
    end

    // One operation; glitch>0 pulses a spurious start with other operands in that RUN cycle.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int glitch);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        bit   got;
        e = model(ta, tb_v);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cyc = 1;
        busy_cnt = 0;
        got = 1'b0;
        while (!got && cyc <= int'(W) + 4) begin
            if (done) begin
                got = 1'b1;
                chk("done_latency", 32'(cyc), 32'(W + 1));
            end else begin
                if (busy) begin
                    busy_cnt++;
                    chk_outputs("hold", pub);
                end
                if (cyc == glitch) begin
                    start = 1'b1;
                    a = 8'h01;
                    b = 8'h01;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(W));
        pub = e;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int   dones;
        int   first_done;
        int   spacing;
        exp_t rst_e;

        rst_e.diff = '0;
        rst_e.borrow = 1'b0;
        rst_e.overflow = 1'b0;
        rst_e.zero = 1'b1;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_outputs("rst", rst_e);
        pub = rst_e;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(8'h35, 8'h12, 0);
        do_op(8'h12, 8'h35, 0);
        do_op(8'h80, 8'h01, 0);
        do_op(8'h7F, 8'hFF, 0);
        do_op(8'hA5, 8'hA5, 0);
        do_op(8'h40, 8'h10, 3);
        do_op(8'h5A, 8'h00, 0);

        // start held high: two back-to-back operations.
        @(negedge clk);
        a = 8'h9C;
        b = 8'h27;
        start = 1'b1;
        sb.push_back(model(8'h9C, 8'h27));
        sb.push_back(model(8'h9C, 8'h27));
        dones = 0;
        first_done = 0;
        spacing = 0;
        for (int i = 1; i <= 40 && dones < 2; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (dones == 1) first_done = i;
                else spacing = i - first_done;
            end
        end
        start = 1'b0;
        chk("held_start_dones", 32'(dones), 32'd2);
        chk("held_start_spacing", 32'(spacing), 32'(W + 2));
        pub = model(8'h9C, 8'h27);
        repeat (W + 3) @(negedge clk);
        chk("held_start_no_third", 32'(busy), 32'd0);

        // Reset in the middle of RUN.
        @(negedge clk);
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk_outputs("mid_rst", rst_e);
        pub = rst_e;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(W) + 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({busy, done}), 32'd0);
        end
        do_op(8'hFF, 8'h01, 0);

        // Randomized operations, including some equal-operand and zero-subtrahend draws.
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 8 == 3) rb = ra;
            if (n % 8 == 5) rb = '0;
            do_op(ra, rb, ((n % 4) == 1) ? int'($urandom_range(1, W)) : 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
